// File: rtl/onehot_ptr_pkg.sv
// Shared definitions for the circular pointer and its select-vector decoder.
package onehot_ptr_pkg;

  localparam int DEC_ONEHOT = 0;
  localparam int DEC_THERM  = 1;

  localparam logic ACT_HIGH = 1'b1;
  localparam logic ACT_LOW  = 1'b0;

  typedef enum logic {PTR_UP, PTR_DOWN} ptr_dir_t;

endpackage

// File: rtl/ptr_dec.sv
// Combinational index decoder: one-hot or thermometer select vector with a selectable active level.
module ptr_dec
  import onehot_ptr_pkg::*;
#(
  parameter int   DEPTH = 8,
  parameter int   MODE  = DEC_ONEHOT,
  parameter logic ACT   = ACT_HIGH,
  localparam int  IN    = $clog2(DEPTH)
) (
  input  logic [IN-1:0]    idx,
  output logic [DEPTH-1:0] vec
);

  always_comb begin
    vec = {DEPTH{~ACT}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((MODE == DEC_THERM) ? (i <= int'(idx)) : (i == int'(idx))) begin
        vec[i] = ACT;
      end
    end
  end

endmodule

// File: rtl/onehot_ptr.sv
// Circular up/down pointer over DEPTH positions with load, registered decode and wrap/error pulses.
module onehot_ptr
  import onehot_ptr_pkg::*;
#(
  parameter int   DEPTH   = 8,
  parameter int   IN      = $clog2(DEPTH),
  parameter int   MODE    = DEC_ONEHOT,
  parameter logic ACT     = ACT_HIGH,
  parameter int   RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IN-1:0]    load_val,
  output logic [IN-1:0]    ptr,
  output logic [DEPTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  // One extra bit keeps DEPTH and DEPTH-1+1 from aliasing when DEPTH is a power of two.
  localparam logic [IN:0]   DEPTH_X = (IN+1)'(DEPTH);
  localparam logic [IN:0]   LAST_X  = DEPTH_X - 1'b1;
  localparam logic [IN-1:0] RST_PTR = IN'(RST_VAL);

  logic [IN-1:0]    ptr_q, ptr_d, dec_idx;
  logic [DEPTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [IN:0]      ptr_x, step_x;

  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    ptr_x  = {1'b0, ptr_q};
    step_x = '0;
    if (load) begin
      if ({1'b0, load_val} < DEPTH_X) begin
        ptr_d = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (ptr_dir_t'(dir) == PTR_DOWN) begin
        if (ptr_x == '0) begin
          ptr_d  = LAST_X[IN-1:0];
          wrap_d = 1'b1;
        end else begin
          step_x = ptr_x - 1'b1;
          ptr_d  = step_x[IN-1:0];
        end
      end else begin
        if (ptr_x == LAST_X) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          step_x = ptr_x + 1'b1;
          ptr_d  = step_x[IN-1:0];
        end
      end
    end
    dec_idx = reset ? RST_PTR : ptr_d;
  end

  // Decode the index the flops are about to hold so out_q always matches ptr_q.
  ptr_dec #(
    .DEPTH (DEPTH),
    .MODE  (MODE),
    .ACT   (ACT)
  ) u_dec (
    .idx (dec_idx),
    .vec (out_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= RST_PTR;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
    out_q <= out_d;
  end

  assign ptr  = ptr_q;
  assign out  = out_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_onehot_ptr.sv
// Directed bench for onehot_ptr: a one-hot DEPTH=6 instance and an active-low thermometer DEPTH=5 instance.
module tb_onehot_ptr;
  import onehot_ptr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       a_reset, a_en, a_dir, a_load;
  logic [2:0] a_load_val, a_ptr;
  logic [5:0] a_out;
  logic       a_wrap, a_err;

  logic       b_reset, b_en, b_dir, b_load;
  logic [2:0] b_load_val, b_ptr;
  logic [4:0] b_out;
  logic       b_wrap, b_err;

  onehot_ptr #(.DEPTH(6), .MODE(DEC_ONEHOT), .ACT(ACT_HIGH), .RST_VAL(0)) dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .dir(a_dir), .load(a_load),
    .load_val(a_load_val), .ptr(a_ptr), .out(a_out), .wrap(a_wrap), .err(a_err)
  );

  onehot_ptr #(.DEPTH(5), .MODE(DEC_THERM), .ACT(ACT_LOW), .RST_VAL(2)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .load(b_load),
    .load_val(b_load_val), .ptr(b_ptr), .out(b_out), .wrap(b_wrap), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] p, input logic [5:0] o,
                       input logic w, input logic e);
    chk({tag, ".ptr"},  32'(a_ptr),  32'(p));
    chk({tag, ".out"},  32'(a_out),  32'(o));
    chk({tag, ".wrap"}, 32'(a_wrap), 32'(w));
    chk({tag, ".err"},  32'(a_err),  32'(e));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] p, input logic [4:0] o,
                       input logic w, input logic e);
    chk({tag, ".ptr"},  32'(b_ptr),  32'(p));
    chk({tag, ".out"},  32'(b_out),  32'(o));
    chk({tag, ".wrap"}, 32'(b_wrap), 32'(w));
    chk({tag, ".err"},  32'(b_err),  32'(e));
  endtask

  logic [2:0] up_ptr  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [5:0] up_out  [6] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
  logic       up_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    a_reset = 1'b1; a_en = 1'b0; a_dir = 1'b0; a_load = 1'b0; a_load_val = '0;
    b_reset = 1'b1; b_en = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_load_val = '0;
    #1;
    tick();
    chk_a("a_reset", 3'd0, 6'b000001, 1'b0, 1'b0);

    // Increment around the ring
    a_reset = 1'b0; a_en = 1'b1; a_dir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_a($sformatf("a_up%0d", i), up_ptr[i], up_out[i], up_wrap[i], 1'b0);
    end

    // Decrement from 0 wraps to DEPTH-1
    a_dir = 1'b1;
    tick();
    chk_a("a_dn_wrap", 3'd5, 6'b100000, 1'b1, 1'b0);
    tick();
    chk_a("a_dn", 3'd4, 6'b010000, 1'b0, 1'b0);

    a_en = 1'b0;
    tick();
    chk_a("a_hold", 3'd4, 6'b010000, 1'b0, 1'b0);

    // Load beats en; out-of-range load holds and flags err
    a_load = 1'b1; a_load_val = 3'd3; a_en = 1'b1; a_dir = 1'b0;
    tick();
    chk_a("a_load3", 3'd3, 6'b001000, 1'b0, 1'b0);
    a_load_val = 3'd7;
    tick();
    chk_a("a_load7", 3'd3, 6'b001000, 1'b0, 1'b1);
    a_load = 1'b0; a_en = 1'b0;
    tick();
    chk_a("a_err_drop", 3'd3, 6'b001000, 1'b0, 1'b0);

    // Thermometer, active low, DEPTH=5, RST_VAL=2
    a_reset = 1'b1;
    b_reset = 1'b1;
    tick();
    chk_b("b_reset", 3'd2, 5'b11000, 1'b0, 1'b0);
    b_reset = 1'b0; b_load = 1'b1; b_load_val = 3'd4;
    tick();
    chk_b("b_load4", 3'd4, 5'b00000, 1'b0, 1'b0);
    b_load_val = 3'd2;
    tick();
    chk_b("b_load2", 3'd2, 5'b11000, 1'b0, 1'b0);
    b_load_val = 3'd0;
    tick();
    chk_b("b_load0", 3'd0, 5'b11110, 1'b0, 1'b0);
    b_load = 1'b0; b_en = 1'b1; b_dir = 1'b1;
    tick();
    chk_b("b_dn_wrap", 3'd4, 5'b00000, 1'b1, 1'b0);
    b_en = 1'b0; b_load = 1'b1; b_load_val = 3'd6;
    tick();
    chk_b("b_load6", 3'd4, 5'b00000, 1'b0, 1'b1);

    // Reset together with load and en wins and clears both pulses
    b_reset = 1'b1; b_load = 1'b1; b_load_val = 3'd1; b_en = 1'b1; b_dir = 1'b0;
    tick();
    chk_b("b_rst_win", 3'd2, 5'b11000, 1'b0, 1'b0);
    b_reset = 1'b0; b_load = 1'b0; b_en = 1'b1; b_dir = 1'b0;
    tick();
    chk_b("b_up", 3'd3, 5'b10000, 1'b0, 1'b0);
    tick();
    chk_b("b_up4", 3'd4, 5'b00000, 1'b0, 1'b0);
    tick();
    chk_b("b_up_wrap", 3'd0, 5'b11110, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
